// File: rtl/ofdm_tx_pkg.sv
// Shared OFDM TX definitions: CP ratio encodings, CP read FSM states and CP length helper.
package ofdm_tx_pkg;

  typedef enum logic [1:0] {
    CP_1_4  = 2'd0,
    CP_1_8  = 2'd1,
    CP_1_16 = 2'd2,
    CP_1_32 = 2'd3
  } cp_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CP   = 2'd1,
    S_DATA = 2'd2
  } rd_state_e;

  function automatic int unsigned cp_len_f(input int unsigned nfft_log2, input logic [1:0] cp_sel);
    return (32'd1 << nfft_log2) >> (32'd2 + 32'(cp_sel));
  endfunction

endpackage

// File: rtl/cp_pp_ram.sv
// Ping-pong symbol buffer: one synchronous write port, one asynchronous read port.
module cp_pp_ram #(
  parameter int unsigned AW = 9,
  parameter int unsigned W  = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: buffers N-sample symbols in two banks, emits last cp_len samples then all N.
// Define CP_FLAG_EN to add the dout_cp / dout_sos sideband outputs.
module cp_inserter
  import ofdm_tx_pkg::*;
#(
  parameter int unsigned NFFT_LOG2 = 8,
  parameter int unsigned DW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cp_sel,
  input  logic [DW-1:0] din_Re,
  input  logic [DW-1:0] din_Im,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] dout_Re,
  output logic [DW-1:0] dout_Im,
  output logic          dout_valid,
  input  logic          dout_ready
`ifdef CP_FLAG_EN
  ,
  output logic          dout_cp,
  output logic          dout_sos
`endif
);

  localparam int unsigned N = 1 << NFFT_LOG2;

  logic [1:0]           r_full;
  logic                 r_wr_bank;
  logic [NFFT_LOG2-1:0] r_wr_cnt;
  logic                 r_rd_bank;
  logic [NFFT_LOG2-1:0] r_rd_idx;
  rd_state_e            r_state;
  logic [DW-1:0]        r_dout_re;
  logic [DW-1:0]        r_dout_im;
  logic                 r_dout_valid;

  logic                 w_wr_en;
  logic                 w_wr_last;
  logic                 w_load;
  logic                 w_rd_last;
  logic [NFFT_LOG2-1:0] w_cp_start;
  logic [2*DW-1:0]      w_rdata;

  assign din_ready  = ~rst & ~r_full[r_wr_bank];
  assign w_wr_en    = din_valid & din_ready;
  assign w_wr_last  = w_wr_en & (&r_wr_cnt);
  assign w_load     = ((r_state == S_CP) || (r_state == S_DATA)) & (~r_dout_valid | dout_ready);
  assign w_rd_last  = w_load & (r_state == S_DATA) & (&r_rd_idx);
  assign w_cp_start = NFFT_LOG2'(N - cp_len_f(NFFT_LOG2, cp_sel));

  cp_pp_ram #(
    .AW (NFFT_LOG2 + 1),
    .W  (2 * DW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr ({r_wr_bank, r_wr_cnt}),
    .i_wdata ({din_Re, din_Im}),
    .i_raddr ({r_rd_bank, r_rd_idx}),
    .o_rdata (w_rdata)
  );

  // Bank-full flags: set by the writer, cleared by the reader; never the same bank on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
    end else begin
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_wr_last) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
      end
      if (w_rd_last) r_full[r_rd_bank] <= 1'b0;
    end
  end

`ifdef CP_FLAG_EN
  logic r_dout_cp;
  logic r_dout_sos;
  logic r_sos_pend;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rd_bank    <= 1'b0;
      r_rd_idx     <= '0;
      r_dout_re    <= '0;
      r_dout_im    <= '0;
      r_dout_valid <= 1'b0;
`ifdef CP_FLAG_EN
      r_dout_cp    <= 1'b0;
      r_dout_sos   <= 1'b0;
      r_sos_pend   <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_dout_re    <= w_rdata[2*DW-1:DW];
        r_dout_im    <= w_rdata[DW-1:0];
        r_dout_valid <= 1'b1;
        r_rd_idx     <= r_rd_idx + 1'b1;
`ifdef CP_FLAG_EN
        r_dout_cp    <= (r_state == S_CP);
        r_dout_sos   <= r_sos_pend;
        r_sos_pend   <= 1'b0;
`endif
      end else if (dout_ready) begin
        r_dout_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state  <= S_CP;
            r_rd_idx <= w_cp_start;
`ifdef CP_FLAG_EN
            r_sos_pend <= 1'b1;
`endif
          end
        end
        // The prefix ends when the index wraps from N-1 back to 0.
        S_CP: begin
          if (w_load && (&r_rd_idx)) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_rd_last) begin
            r_rd_bank <= ~r_rd_bank;
            if (r_full[~r_rd_bank]) begin
              r_state  <= S_CP;
              r_rd_idx <= w_cp_start;
`ifdef CP_FLAG_EN
              r_sos_pend <= 1'b1;
`endif
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout_Re    = r_dout_re;
  assign dout_Im    = r_dout_im;
  assign dout_valid = r_dout_valid;
`ifdef CP_FLAG_EN
  assign dout_cp    = r_dout_cp;
  assign dout_sos   = r_dout_sos;
`endif

endmodule

// File: tb/tb_cp_inserter.sv
// Scoreboard bench for cp_inserter: stimulus pushes expected samples, a monitor pops and compares.
module tb_cp_inserter;
  import ofdm_tx_pkg::*;

  localparam int unsigned NL = 8;
  localparam int unsigned N  = 256;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cp_sel;
  logic [DW-1:0] din_Re, din_Im, dout_Re, dout_Im;
  logic          din_valid, din_ready, dout_valid, dout_ready;
`ifdef CP_FLAG_EN
  logic          dout_cp, dout_sos;
`endif

  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_stall  = 0;
  bit  rnd_mode = 1'b0;
  bit  gap_mode = 1'b0;
  logic [33:0] sb[$];

  always #5 clk = ~clk;

  cp_inserter #(
    .NFFT_LOG2 (NL),
    .DW        (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cp_sel     (cp_sel),
    .din_Re     (din_Re),
    .din_Im     (din_Im),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout_Re    (dout_Re),
    .dout_Im    (dout_Im),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
`ifdef CP_FLAG_EN
    ,
    .dout_cp    (dout_cp),
    .dout_sos   (dout_sos)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [33:0] act_word();
`ifdef CP_FLAG_EN
    return {dout_cp, dout_sos, dout_Re, dout_Im};
`else
    return {2'b00, dout_Re, dout_Im};
`endif
  endfunction

  // Monitor: samples just after the falling edge, when inputs for the next edge are settled.
  logic [33:0] held_v;
  bit          held = 1'b0;
  always begin
    logic [33:0] act;
    @(negedge clk);
    #1;
    act = act_word();
    if (held) begin
      chk("hold valid", 64'(dout_valid), 64'd1);
      if (dout_valid) chk("hold data", 64'(act), 64'(held_v));
    end
    if (!rst && dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL extra output: got %h required none", act);
      end else begin
        chk("dout", 64'(act), 64'(sb.pop_front()));
      end
    end
    held   = !rst && dout_valid && !dout_ready;
    held_v = act;
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_mode) dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_sym(input logic [7:0] tag, input logic [1:0] sel);
    int unsigned cp;
    cp = cp_len_f(NL, sel);
    for (int j = 0; j < int'(N + cp); j++) begin
      logic [7:0]  idx;
      logic [15:0] re;
      logic        cpf, sos;
      idx = (j < int'(cp)) ? 8'(N - cp + j) : 8'(j - cp);
      re  = {tag, idx};
`ifdef CP_FLAG_EN
      cpf = (j < int'(cp));
      sos = (j == 0);
`else
      cpf = 1'b0;
      sos = 1'b0;
`endif
      sb.push_back({cpf, sos, re, 16'(-re)});
    end
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im);
    int wt = 0;
    if (gap_mode) repeat ($urandom_range(0, 2)) tick();
    din_valid = 1'b1;
    din_Re    = re;
    din_Im    = im;
    while (!din_ready && wt < 3000) begin
      tick();
      wt++;
    end
    if (wt > 0) n_stall++;
    if (wt >= 3000) begin
      chk("din_ready timeout", 64'(din_ready), 64'd1);
      din_valid = 1'b0;
      return;
    end
    @(posedge clk);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send_sym(input logic [7:0] tag);
    for (int k = 0; k < int'(N); k++) begin
      logic [15:0] re;
      re = {tag, 8'(k)};
      send(re, 16'(-re));
    end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!dout_valid && t < 1000) begin
      tick();
      t++;
    end
    chk("valid timeout", 64'(dout_valid), 64'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 20000) begin
      tick();
      t++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    repeat (4) tick();
    chk("idle after drain", 64'(dout_valid), 64'd0);
  endtask

  initial begin
    int gaps;
    rst        = 1'b1;
    din_valid  = 1'b0;
    din_Re     = '0;
    din_Im     = '0;
    dout_ready = 1'b1;
    cp_sel     = CP_1_4;
    tick();
    #1;
    chk("rst din_ready", 64'(din_ready), 64'd0);
    chk("rst dout_valid", 64'(dout_valid), 64'd0);
    chk("rst dout_Re", 64'(dout_Re), 64'd0);
    chk("rst dout_Im", 64'(dout_Im), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post-rst din_ready", 64'(din_ready), 64'd1);

    // One symbol, 1/4 CP, latency check.
    push_sym(8'h00, CP_1_4);
    send_sym(8'h00);
    #1;
    chk("latency e0", 64'(dout_valid), 64'd0);
    tick();
    #1;
    chk("latency e1", 64'(dout_valid), 64'd0);
    tick();
    #1;
    chk("latency e2", 64'(dout_valid), 64'd1);
    drain();

    // Four back-to-back symbols at 1/32 CP; output must be gapless.
    cp_sel  = CP_1_32;
    n_stall = 0;
    gaps    = 0;
    fork
      begin
        for (int s = 0; s < 4; s++) begin
          push_sym(8'(8'h01 + s), CP_1_32);
          send_sym(8'(8'h01 + s));
        end
      end
      begin
        wait_valid();
        for (int i = 1; i < 4 * 264; i++) begin
          tick();
          if (!dout_valid) gaps++;
        end
      end
    join
    chk("gapless", 64'(gaps), 64'd0);
    chk("input stalled", 64'(n_stall > 0), 64'd1);
    drain();

    // Random backpressure and input gaps at 1/8 CP.
    cp_sel   = CP_1_8;
    rnd_mode = 1'b1;
    gap_mode = 1'b1;
    for (int s = 0; s < 3; s++) begin
      push_sym(8'(8'h30 + s), CP_1_8);
      send_sym(8'(8'h30 + s));
    end
    drain();
    rnd_mode   = 1'b0;
    gap_mode   = 1'b0;
    dout_ready = 1'b1;

    // cp_sel change mid-output applies only to the following symbol.
    cp_sel = CP_1_4;
    push_sym(8'h10, CP_1_4);
    send_sym(8'h10);
    wait_valid();
    cp_sel = CP_1_16;
    push_sym(8'h11, CP_1_16);
    send_sym(8'h11);
    drain();

    // Reset while stalled in the prefix with both banks full.
    cp_sel     = CP_1_4;
    dout_ready = 1'b0;
    send_sym(8'h20);
    send_sym(8'h21);
    repeat (3) tick();
    #1;
    chk("both full din_ready", 64'(din_ready), 64'd0);
    chk("stalled dout_valid", 64'(dout_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("in-rst din_ready", 64'(din_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("after rst dout_valid", 64'(dout_valid), 64'd0);
    chk("after rst din_ready", 64'(din_ready), 64'd1);
    chk("after rst dout_Re", 64'(dout_Re), 64'd0);
    dout_ready = 1'b1;
    push_sym(8'h22, CP_1_4);
    send_sym(8'h22);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
